// File: rtl/bidir_pkg.sv
// Shared types and default parameters for the bidirectional port controller.
package bidir_pkg;

    localparam int unsigned DEF_WIDTH       = 8;
    localparam int unsigned DEF_TURN        = 2;
    localparam int unsigned DEF_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        RX      = 2'd0,
        TURN_TX = 2'd1,
        TX      = 2'd2,
        TURN_RX = 2'd3
    } bidir_state_t;

endpackage

// File: rtl/bidir_sync.sv
// WIDTH x STAGES flop chain resynchronising the inbound bus.
module bidir_sync #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= d;
            for (int i = 1; i < int'(STAGES); i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/bidir_port_ctrl.sv
// Bidirectional port controller: direction FSM with tristate dead-time,
// registered outbound drive and synchronised inbound sampling.
module bidir_port_ctrl
    import bidir_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned TURN        = DEF_TURN,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dir_req,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             oe,
    output logic             busy,
    inout  wire  [WIDTH-1:0] io
);

    localparam int unsigned CW = $clog2(TURN + 1);
    localparam int unsigned RW = $clog2(SYNC_STAGES + 1);

    bidir_state_t     state;
    logic [CW-1:0]    turn_cnt;
    logic [RW-1:0]    rx_cnt;
    logic [WIDTH-1:0] out_reg;

    // Pad driven only from flops; reset clears oe asynchronously, releasing io.
    assign io = oe ? out_reg : {WIDTH{1'bz}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RX;
            turn_cnt <= '0;
            rx_cnt   <= '0;
            out_reg  <= '0;
            oe       <= 1'b0;
            wr_ready <= 1'b0;
            busy     <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            if (wr_valid && wr_ready) begin
                out_reg <= wr_data;
            end
            rd_valid <= 1'b0;
            rx_cnt   <= '0;
            unique case (state)
                RX: begin
                    if (dir_req) begin
                        state    <= TURN_TX;
                        turn_cnt <= '0;
                        busy     <= 1'b1;
                    end else begin
                        // rd_valid only once the chain holds SYNC_STAGES fresh RX samples
                        rx_cnt   <= (rx_cnt == RW'(SYNC_STAGES)) ? rx_cnt : rx_cnt + 1'b1;
                        rd_valid <= (rx_cnt >= RW'(SYNC_STAGES - 1));
                    end
                end
                TURN_TX: begin
                    turn_cnt <= turn_cnt + 1'b1;
                    if (turn_cnt == CW'(TURN - 1)) begin
                        state    <= TX;
                        oe       <= 1'b1;
                        wr_ready <= 1'b1;
                        busy     <= 1'b0;
                    end
                end
                TX: begin
                    if (!dir_req) begin
                        state    <= TURN_RX;
                        turn_cnt <= '0;
                        oe       <= 1'b0;
                        wr_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                TURN_RX: begin
                    turn_cnt <= turn_cnt + 1'b1;
                    if (turn_cnt == CW'(TURN - 1)) begin
                        state <= RX;
                        busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

    bidir_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (io),
        .q     (rd_data)
    );

endmodule

// File: tb/tb_bidir_port_ctrl.sv
// Directed + randomized bench for bidir_port_ctrl against a behavioural direction/timing model.
module tb_bidir_port_ctrl;

    localparam int unsigned WIDTH       = 8;
    localparam int unsigned TURN        = 2;
    localparam int unsigned SYNC_STAGES = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             dir_req;
    logic [WIDTH-1:0] wr_data;
    logic             wr_valid;
    logic             wr_ready;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             oe;
    logic             busy;
    logic [WIDTH-1:0] tb_val;
    logic             tb_drive;
    wire  [WIDTH-1:0] io;

    // Far-end device on the shared bus
    assign io = tb_drive ? tb_val : {WIDTH{1'bz}};

    always #5 clk = ~clk;

    bidir_port_ctrl #(
        .WIDTH       (WIDTH),
        .TURN        (TURN),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .dir_req  (dir_req),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .oe       (oe),
        .busy     (busy),
        .io       (io)
    );

    int total = 0;
    int bad   = 0;

    // Model: settled direction, pending turnaround, consecutive receive cycles
    bit               m_tx;
    bit               m_turning;
    bit               m_target;
    int               m_left;
    int               m_rx_run;
    logic [WIDTH-1:0] m_out;
    logic [WIDTH-1:0] hist [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_drive();
        return m_tx && !m_turning;
    endfunction

    function automatic bit exp_in_rx();
        return !m_tx && !m_turning;
    endfunction

    task automatic model_reset();
        m_tx      = 1'b0;
        m_turning = 1'b0;
        m_target  = 1'b0;
        m_left    = 0;
        m_rx_run  = 0;
        m_out     = '0;
        hist.delete();
    endtask

    task automatic model_edge();
        logic [WIDTH-1:0] sample;
        bit               hs;
        bit               was_rx;
        if (exp_drive())   sample = m_out;
        else if (tb_drive) sample = tb_val;
        else               sample = 'x;
        hist.push_back(sample);
        if (hist.size() > SYNC_STAGES) void'(hist.pop_front());
        hs     = exp_drive() && wr_valid;
        was_rx = exp_in_rx();
        if (m_turning) begin
            m_left--;
            if (m_left == 0) begin
                m_turning = 1'b0;
                m_tx      = m_target;
            end
        end else if (!m_tx && dir_req) begin
            m_turning = 1'b1;
            m_target  = 1'b1;
            m_left    = TURN;
        end else if (m_tx && !dir_req) begin
            m_turning = 1'b1;
            m_target  = 1'b0;
            m_left    = TURN;
            m_tx      = 1'b0;
        end
        if (hs) m_out = wr_data;
        if (exp_in_rx()) m_rx_run = was_rx ? m_rx_run + 1 : 0;
        else             m_rx_run = 0;
    endtask

    task automatic check_outputs();
        bit ev;
        ev = (m_rx_run >= int'(SYNC_STAGES));
        chk("oe", 32'(oe), 32'(exp_drive()));
        chk("wr_ready", 32'(wr_ready), 32'(exp_drive()));
        chk("busy", 32'(busy), 32'(m_turning));
        chk("rd_valid", 32'(rd_valid), 32'(ev));
        chk("overlap", 32'(oe & tb_drive), 32'd0);
        if (exp_drive()) chk("io_tx", 32'(io), 32'(m_out));
        if (tb_drive)    chk("io_rx", 32'(io), 32'(tb_val));
        if (ev && hist.size() == SYNC_STAGES) chk("rd_data", 32'(rd_data), 32'(hist[0]));
    endtask

    // One clock: model advances on the edge, DUT checked on the falling edge
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
        tb_drive = !(m_tx || (m_turning && m_target));
    endtask

    initial begin
        rst_n    = 1'b0;
        dir_req  = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        tb_val   = 8'hA5;
        tb_drive = 1'b1;
        model_reset();
        #1;
        chk("rst_oe", 32'(oe), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Bus pulled to A5: rd_valid after SYNC_STAGES cycles
        repeat (4) step();

        // Turn to TX
        dir_req = 1'b1;
        repeat (5) step();

        // Back-to-back handshakes, then hold
        wr_valid = 1'b1; wr_data = 8'h3C; step();
        wr_data = 8'hC3; step();
        wr_valid = 1'b0; repeat (3) step();

        // Reversal mid-turn: full TURN_RX, one RX cycle, then TURN_TX
        dir_req = 1'b0; step();
        dir_req = 1'b1; repeat (8) step();

        // Handshake attempts in RX and turnarounds are ignored
        dir_req = 1'b0; wr_valid = 1'b1; wr_data = 8'h77; repeat (6) step();
        dir_req = 1'b1; repeat (2) step();
        wr_valid = 1'b0; repeat (3) step();

        // Handshake in the cycle dir_req falls is accepted but not driven
        dir_req = 1'b0; wr_valid = 1'b1; wr_data = 8'h5A; step();
        wr_valid = 1'b0; repeat (6) step();
        dir_req = 1'b1; repeat (4) step();

        // Async reset mid-TX while driving FF
        wr_valid = 1'b1; wr_data = 8'hFF; step();
        wr_valid = 1'b0; step();
        #2 rst_n = 1'b0;
        #1;
        chk("async_oe", 32'(oe), 32'd0);
        chk("async_wr_ready", 32'(wr_ready), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        model_reset();
        tb_drive = 1'b1;
        tb_val   = 8'h96;
        @(negedge clk);
        chk("rst_hold_oe", 32'(oe), 32'd0);
        rst_n = 1'b1;
        repeat (4) step();
        // out_reg cleared by reset: TX drives zero without a handshake
        repeat (5) step();

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(7) == 0) dir_req = ~dir_req;
            wr_valid = 1'($urandom_range(1));
            wr_data  = WIDTH'($urandom);
            tb_val   = WIDTH'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bidir_port_ctrl.md
# bidir_port_ctrl

Parametrised, clocked bidirectional port controller. It is the successor to the plain tristate buffer. It owns one WIDTH-bit `inout` bus and arbitrates direction with a four-state FSM. Both direction changes insert a programmable tristate dead-time, so the bus is never driven from both ends at once. Outbound data uses a valid/ready handshake and drives the pad from registers; inbound data passes through a multi-stage synchroniser. The block sits between core logic and a shared off-chip or inter-block data bus.

## Interface
- `WIDTH`, 8, bus width in bits (≥1)
- `TURN`, 2, tristate dead-time cycles per direction change (≥1)
- `SYNC_STAGES`, 2, inbound synchroniser depth (≥2)

- `clk` input 1: single clock, rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `dir_req` input 1: level; 1 = request to drive `io`, 0 = request to receive
- `wr_data` input WIDTH: outbound word
- `wr_valid` input 1: `wr_data` valid
- `wr_ready` output 1: block accepts `wr_data`
- `rd_data` output WIDTH: synchronised `io` value
- `rd_valid` output 1: `rd_data` reflects the bus in receive mode
- `oe` output 1: 1 while the block drives `io`
- `busy` output 1: 1 during turnaround
- `io` inout WIDTH: bidirectional bus

## Operation
- States:
  - `RX`: `io` is Z and is sampled.
  - `TURN_TX`: dead-time before driving; `io` is Z.
  - `TX`: `io` is driven.
  - `TURN_RX`: dead-time before receiving; `io` is Z.
- Transitions:
  - `RX`→`TURN_TX` when `dir_req`=1.
  - `TURN_TX`→`TX` when the turn counter reaches `TURN`.
  - `TX`→`TURN_RX` when `dir_req`=0.
  - `TURN_RX`→`RX` when the turn counter reaches `TURN`.
- A turnaround always completes, whatever `dir_req` does during it. `dir_req` is re-evaluated only in `RX` and `TX`. A request reversal mid-turn therefore costs a full opposite turnaround.
- Turn counter: width $clog2(TURN+1). It clears on entry to each turnaround state.
- `io` = `oe` ? `out_reg` : Z. Both `oe` and `out_reg` are flops; no combinational path from inputs to the pad.
- `wr_ready` = 1 only in `TX`.
  - A handshake (`wr_valid`&`wr_ready`) loads `out_reg`.
  - `out_reg` holds its value until the next handshake, including across direction changes.
  - Outside `TX`, `wr_valid` is ignored and no data is lost or queued.
- Inbound path:
  - A `SYNC_STAGES`-deep flop chain samples `io` every cycle, and `rd_data` = the last stage.
  - `rd_valid` = 1 only in `RX`, and only after `SYNC_STAGES` consecutive `RX` cycles (pipeline flushed of stale or own-driven data).
  - `rd_valid` drops in the cycle the FSM leaves `RX`.
- `busy` = state is `TURN_TX` or `TURN_RX`.
- Reset values:
  - State `RX`; `oe`=0, so `io`=Z.
  - `out_reg`=0, sync chain=0, `rd_data`=0.
  - `rd_valid`=0, `wr_ready`=0, `busy`=0, turn counter=0.
- Reset asserted mid-operation: `io` releases to Z asynchronously and immediately. All state returns to the reset values.

## Timing
- `dir_req` sampled 1 at edge k, in `RX`:
  - `TURN_TX` from k+1, `busy`=1 for `TURN` cycles.
  - `TX`, `oe`=1, `wr_ready`=1 from edge k+1+`TURN`.
- Handshake at edge m: `out_reg` and `io` show the word from m+1. Throughput is one word per cycle.
- `dir_req` sampled 0 at edge k, in `TX`:
  - `oe`=0 and `io`=Z from k+1.
  - `RX` from k+1+`TURN`.
  - `rd_valid`=1 from k+1+`TURN`+`SYNC_STAGES`.
- Input-to-`rd_data` latency in a stable `RX`: `SYNC_STAGES` cycles.
- A handshake in the same cycle that `dir_req` falls is accepted. That word is driven for zero cycles and remains in `out_reg`.

## Structure
- Package `bidir_pkg`:
  - state enum `bidir_state_t` {`RX`, `TURN_TX`, `TX`, `TURN_RX`}
  - default parameter constants
- Sub-module `bidir_sync`: a WIDTH × STAGES flop chain with async active-low reset, instantiated once for the inbound path.

## Test plan
With `WIDTH`=8, `TURN`=2, `SYNC_STAGES`=2:
- Reset, then release with bus pulled to 8'hA5 → `io`=Z, `oe`=0. `rd_valid` rises 2 cycles after reset release, with `rd_data`=8'hA5.
- `dir_req`=1 at edge 10 → `busy`=1 at cycles 11–12, `io`=Z throughout. `oe`=`wr_ready`=1 at edge 13.
- In `TX`, handshakes 8'h3C at edge 20 and 8'hC3 at edge 21 → `io`=8'h3C in cycle 21 and 8'hC3 in cycle 22, held while `wr_valid`=0.
- `dir_req`=0 at edge 30, then back to 1 at edge 31 → `oe`=0 at 31, `TURN_RX` runs its full 2 cycles, `RX` for one cycle, then `TURN_TX`. `rd_valid` never asserts and there is no drive overlap.
- `rst_n` low mid-`TX` while driving 8'hFF → `io`=Z with no clock edge. After release: state `RX`, `out_reg`=0.
- Handshake attempts with `wr_valid`=1 in `RX` and during turnarounds → `wr_ready`=0 and `out_reg` unchanged.
